// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the FP MAC sequencer: state encoding,
// LCD status codes and default geometry.
package fp_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_A   = 3'd1,
        ST_LOAD_B   = 3'd2,
        ST_MAC_RD   = 3'd3,
        ST_MAC_REQ  = 3'd4,
        ST_MAC_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam logic [4:0] ARD_IDLE   = 5'h00;
    localparam logic [4:0] ARD_LOAD_A = 5'h01;
    localparam logic [4:0] ARD_LOAD_B = 5'h02;
    localparam logic [4:0] ARD_MAC    = 5'h03;
    localparam logic [4:0] ARD_DONE   = 5'h04;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 4;

    function automatic logic [4:0] arduino_code(input state_e s);
        case (s)
            ST_IDLE:                            return ARD_IDLE;
            ST_LOAD_A:                          return ARD_LOAD_A;
            ST_LOAD_B:                          return ARD_LOAD_B;
            ST_MAC_RD, ST_MAC_REQ, ST_MAC_WAIT: return ARD_MAC;
            ST_DONE:                            return ARD_DONE;
            default:                            return ARD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fp_mac_seq_ctrl_if.sv
// SRAM and FMA bus between the sequencer (master) and the memories / FMA unit (slave).
interface fp_mac_seq_ctrl_if
    import fp_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_wdata;
    logic              o_sram_a_we;
    logic              o_sram_b_we;
    logic              o_sram_re;
    logic [DATA_W-1:0] i_sram_a_rdata;
    logic [DATA_W-1:0] i_sram_b_rdata;
    logic              o_fma_valid;
    logic [DATA_W-1:0] o_fma_a;
    logic [DATA_W-1:0] o_fma_b;
    logic [DATA_W-1:0] o_fma_c;
    logic              i_fma_ready;
    logic              i_fma_done;
    logic [DATA_W-1:0] i_fma_result;

    modport master (
        output o_sram_addr, o_sram_wdata, o_sram_a_we, o_sram_b_we, o_sram_re,
        input  i_sram_a_rdata, i_sram_b_rdata,
        output o_fma_valid, o_fma_a, o_fma_b, o_fma_c,
        input  i_fma_ready, i_fma_done, i_fma_result
    );

    modport slave (
        input  o_sram_addr, o_sram_wdata, o_sram_a_we, o_sram_b_we, o_sram_re,
        output i_sram_a_rdata, i_sram_b_rdata,
        input  o_fma_valid, o_fma_a, o_fma_b, o_fma_c,
        output i_fma_ready, i_fma_done, i_fma_result
    );

endinterface

// File: rtl/fp_mac_btn_sync.sv
// Two-flop synchroniser plus rising-edge detect for a level push button;
// one press pulse per 0->1 transition.
module fp_mac_btn_sync
    import fp_mac_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], i_btn};
        prev_d = sync_q[1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_press = sync_q[1] & ~prev_q;

endmodule

// File: rtl/fp_mac_seq_ctrl.sv
// Keypad-to-SRAM loader and dot-product sequencer driving an external FMA unit.
// Define FP_MAC_SEQ_BTN_EDGE_EN to treat i_push_btn as a level with edge detect.
module fp_mac_seq_ctrl
    import fp_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push_btn,
    input  logic [7:0]           i_keypad,
    fp_mac_seq_ctrl_if.master    bus,
    output logic [DATA_W-1:0]    o_result,
    output logic                 o_result_valid,
    output logic [4:0]           o_arduino,
    output logic [2:0]           o_state
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                BCNT_W    = $clog2(BYTES) + 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                a_we_q, a_we_d;
    logic                b_we_q, b_we_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic                op_lat_q, op_lat_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                press;

`ifdef FP_MAC_SEQ_BTN_EDGE_EN
    fp_mac_btn_sync u_btn_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_push_btn),
        .o_press (press)
    );
`else
    assign press = i_push_btn;
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        addr_d         = addr_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        a_we_d         = 1'b0;
        b_we_d         = 1'b0;
        opa_d          = opa_q;
        opb_d          = opb_q;
        op_lat_d       = op_lat_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d    = ST_LOAD_A;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                // Write cycle: advance the index, or leave the load phase after the last word.
                if (a_we_q || b_we_q) begin
                    if (addr_q == LAST_IDX) begin
                        addr_d  = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_MAC_RD;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (press && state_d != ST_MAC_RD) begin
                    word_d = {word_q[DATA_W-9:0], i_keypad};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        if (state_q == ST_LOAD_A) a_we_d = 1'b1;
                        else                      b_we_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_MAC_RD: begin
                op_lat_d = 1'b0;
                state_d  = ST_MAC_REQ;
            end
            ST_MAC_REQ: begin
                // Read data is live only in the first request cycle; hold a copy for backpressure.
                if (!op_lat_q) begin
                    opa_d    = bus.i_sram_a_rdata;
                    opb_d    = bus.i_sram_b_rdata;
                    op_lat_d = 1'b1;
                end
                if (bus.i_fma_ready) state_d = ST_MAC_WAIT;
            end
            ST_MAC_WAIT: begin
                if (bus.i_fma_done) begin
                    acc_d = bus.i_fma_result;
                    if (addr_q == LAST_IDX) begin
                        state_d        = ST_DONE;
                        result_d       = bus.i_fma_result;
                        result_valid_d = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_MAC_RD;
                    end
                end
            end
            ST_DONE: begin
                if (press) begin
                    state_d        = ST_LOAD_A;
                    acc_d          = '0;
                    result_d       = '0;
                    result_valid_d = 1'b0;
                    addr_d         = '0;
                    byte_cnt_d     = '0;
                    word_d         = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            addr_q         <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            a_we_q         <= 1'b0;
            b_we_q         <= 1'b0;
            opa_q          <= '0;
            opb_q          <= '0;
            op_lat_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            addr_q         <= addr_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            a_we_q         <= a_we_d;
            b_we_q         <= b_we_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            op_lat_q       <= op_lat_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_wdata = word_q;
    assign bus.o_sram_a_we  = a_we_q;
    assign bus.o_sram_b_we  = b_we_q;
    assign bus.o_sram_re    = (state_q == ST_MAC_RD);
    assign bus.o_fma_valid  = (state_q == ST_MAC_REQ);
    assign bus.o_fma_a      = op_lat_q ? opa_q : bus.i_sram_a_rdata;
    assign bus.o_fma_b      = op_lat_q ? opb_q : bus.i_sram_b_rdata;
    assign bus.o_fma_c      = acc_q;

    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_arduino      = arduino_code(state_q);
    assign o_state        = state_q;

endmodule

// File: tb/tb_fp_mac_seq_ctrl.sv
// Self-checking bench: SRAM and FMA models, directed vector table, hand-written
// corner sequences and randomized dot products against a folded-sum reference.
module tb_fp_mac_seq_ctrl;
    import fp_mac_pkg::*;

    localparam int DW  = 32;
    localparam int DEP = 2;
    localparam int AW  = 4;
    localparam int NB  = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn = 1'b0;
    logic [7:0]    keypad = 8'h00;
    logic [DW-1:0] o_result;
    logic          o_result_valid;
    logic [4:0]    o_arduino;
    logic [2:0]    o_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_mac_seq_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fp_mac_seq_ctrl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_push_btn     (btn),
        .i_keypad       (keypad),
        .bus            (bus.master),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_arduino      (o_arduino),
        .o_state        (o_state)
    );

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] rd_a = '0, rd_b = '0;
    int            wr_a_cnt = 0, wr_b_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;

    always @(posedge clk) begin
        if (bus.o_sram_a_we) begin
            mem_a[bus.o_sram_addr] <= bus.o_sram_wdata;
            wr_a_cnt     <= wr_a_cnt + 1;
            last_wr_addr <= bus.o_sram_addr;
        end
        if (bus.o_sram_b_we) begin
            mem_b[bus.o_sram_addr] <= bus.o_sram_wdata;
            wr_b_cnt     <= wr_b_cnt + 1;
            last_wr_addr <= bus.o_sram_addr;
        end
        if (bus.o_sram_re) begin
            rd_a <= mem_a[bus.o_sram_addr];
            rd_b <= mem_b[bus.o_sram_addr];
        end
    end
    assign bus.i_sram_a_rdata = rd_a;
    assign bus.i_sram_b_rdata = rd_b;

    // ---------------- FMA model ----------------
    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:23] == 8'd0) return 0.0;
        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    bit            fma_fp = 1'b0;
    bit            fma_auto = 1'b1;
    int            fma_lat = 5;
    int            ready_mode = 1;
    logic          ready_rnd = 1'b0;
    logic          man_done = 1'b0;
    logic          auto_done = 1'b0;
    logic          busy = 1'b0;
    int            lat_cnt = 0;
    int            req_cnt = 0;
    logic [DW-1:0] res_pend = '0, res_out = '0;

    function automatic logic [DW-1:0] fma_calc(input logic [DW-1:0] a, b, c, input bit fp);
        if (fp) return r2sp(sp2r(a) * sp2r(b) + sp2r(c));
        return a * b + c;
    endfunction

    always @(negedge clk) ready_rnd <= 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        auto_done <= 1'b0;
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            if (busy) begin
                if (lat_cnt <= 1) begin
                    auto_done <= 1'b1;
                    res_out   <= res_pend;
                    busy      <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
            if (bus.o_fma_valid && bus.i_fma_ready) begin
                req_cnt <= req_cnt + 1;
                if (fma_auto) begin
                    busy     <= 1'b1;
                    lat_cnt  <= fma_lat;
                    res_pend <= fma_calc(bus.o_fma_a, bus.o_fma_b, bus.o_fma_c, fma_fp);
                end
            end
        end
    end
    assign bus.i_fma_ready  = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? ready_rnd : 1'b0;
    assign bus.i_fma_done   = auto_done | man_done;
    assign bus.i_fma_result = man_done ? 32'hDEADBEEF : res_out;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic press_byte(input logic [7:0] b);
        keypad = b;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
`ifdef FP_MAC_SEQ_BTN_EDGE_EN
        repeat (4) @(negedge clk);
`else
        @(negedge clk);
`endif
    endtask

    task automatic enter_word(input logic [DW-1:0] w);
        for (int i = 0; i < NB; i++) press_byte(w[DW-1-8*i -: 8]);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (o_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, o_state, s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full load + dot product; expected value supplied by the caller.
    task automatic run_vector(input bit start_press, input logic [DW-1:0] a0, a1, b0, b1,
                              input logic [DW-1:0] exp_res, input string name);
        int req0 = req_cnt;
        if (start_press) press_byte(8'hA5);
        enter_word(a0);
        enter_word(a1);
        enter_word(b0);
        enter_word(b1);
        wait_state(ST_DONE, 600, {name, "_state"});
        chk({name, "_memA1"}, mem_a[1], a1);
        chk({name, "_memB0"}, mem_b[0], b0);
        chk({name, "_result"}, o_result, exp_res);
        chk({name, "_valid"}, o_result_valid, 1'b1);
        chk({name, "_ard"}, o_arduino, ARD_DONE);
        chk({name, "_nreq"}, req_cnt - req0, DEP);
    endtask

    typedef struct {
        logic [DW-1:0] a0, a1, b0, b1;
        bit            fp;
        logic [DW-1:0] exp_res;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req0, wr0, n;
        logic [DW-1:0] ra [DEP];
        logic [DW-1:0] rb [DEP];
        logic [DW-1:0] model_acc;

        vecs[0] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0001_0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0007};
        vecs[2] = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{32'h7, 32'h100, 32'h6, 32'h10, 1'b0, 32'h0000_102A};
        vecs[4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b1, 32'h40C0_0000};
        vecs[5] = '{32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 32'h40A0_0000, 1'b1, 32'h4188_0000};

        // ---- reset state ----
        do_reset();
        chk("rst_state", o_state, ST_IDLE);
        chk("rst_result", o_result, 0);
        chk("rst_valid", o_result_valid, 0);
        chk("rst_ard", o_arduino, ARD_IDLE);
        chk("rst_strobes", {bus.o_sram_a_we, bus.o_sram_b_we, bus.o_sram_re, bus.o_fma_valid}, 0);

        // ---- byte assembly + FP dot product ----
        fma_fp = 1'b1;
        press_byte(8'h00);
        chk("enter_state", o_state, ST_LOAD_A);
        chk("enter_ard", o_arduino, ARD_LOAD_A);
        press_byte(8'h3F);
        press_byte(8'h80);
        press_byte(8'h00);
        repeat (2) @(negedge clk);
        chk("no_wr_3bytes", wr_a_cnt, 0);
        press_byte(8'h00);
        repeat (2) @(negedge clk);
        chk("wr_count", wr_a_cnt, 1);
        chk("wr_addr", last_wr_addr, 0);
        chk("wr_data", mem_a[0], 32'h3F80_0000);
        req0 = req_cnt;
        enter_word(32'h4000_0000);
        chk("loadb_state", o_state, ST_LOAD_B);
        chk("loadb_ard", o_arduino, ARD_LOAD_B);
        enter_word(32'h4000_0000);
        enter_word(32'h4000_0000);
        wait_state(ST_DONE, 600, "fp_done_state");
        chk("fp_result", o_result, 32'h40C0_0000);
        chk("fp_valid", o_result_valid, 1'b1);
        chk("fp_ard", o_arduino, ARD_DONE);
        chk("fp_nreq", req_cnt - req0, 2);

        // ---- press in DONE ----
        press_byte(8'hFF);
        chk("done_press_state", o_state, ST_LOAD_A);
        chk("done_press_valid", o_result_valid, 1'b0);
        chk("done_press_result", o_result, 0);
        fma_fp = 1'b0;
        run_vector(1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd11, "after_done");

        // ---- vector table ----
        for (int v = 0; v < 6; v++) begin
            fma_fp = vecs[v].fp;
            run_vector(1'b1, vecs[v].a0, vecs[v].a1, vecs[v].b0, vecs[v].b1,
                       vecs[v].exp_res, $sformatf("vec%0d", v));
        end
        fma_fp = 1'b0;

        // ---- backpressure ----
        ready_mode = 0;
        req0 = req_cnt;
        press_byte(8'h01);
        enter_word(32'd5);
        enter_word(32'd6);
        enter_word(32'd7);
        enter_word(32'd8);
        wait_state(ST_MAC_REQ, 100, "bp_req_state");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),
                {bus.o_fma_valid, bus.o_fma_a[15:0], bus.o_fma_b[15:0], bus.o_fma_c[15:0]},
                {1'b1, 16'd5, 16'd7, 16'd0});
        end
        chk("bp_noaccept", req_cnt - req0, 0);
        ready_mode = 1;
        @(negedge clk);
        chk("bp_accept_once", req_cnt - req0, 1);
        chk("bp_wait_state", o_state, ST_MAC_WAIT);
        wait_state(ST_DONE, 200, "bp_done_state");
        chk("bp_result", o_result, 32'd83);
        chk("bp_nreq", req_cnt - req0, 2);

        // ---- ignored presses in MAC phase ----
        press_byte(8'h02);
        enter_word(32'd2);
        enter_word(32'd3);
        enter_word(32'd4);
        enter_word(32'd5);
        wait_state(ST_MAC_WAIT, 100, "ign_wait_state");
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        chk("ign_press_wait", o_state, ST_MAC_WAIT);
        n = 0;
        while (!bus.i_fma_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ign_done_seen", bus.i_fma_done, 1'b1);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        chk("ign_coincident", o_state, ST_MAC_RD);
        wait_state(ST_DONE, 200, "ign_done_state");
        chk("ign_result", o_result, 32'd23);

        // ---- reset mid MAC_WAIT with late done ----
        fma_auto = 1'b0;
        press_byte(8'h03);
        enter_word(32'd9);
        enter_word(32'd9);
        enter_word(32'd9);
        enter_word(32'd9);
        wait_state(ST_MAC_WAIT, 100, "rstw_wait_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk("rstw_state", o_state, ST_IDLE);
        chk("rstw_result", o_result, 0);
        chk("rstw_valid", o_result_valid, 0);
        chk("rstw_strobes", {bus.o_sram_a_we, bus.o_sram_b_we, bus.o_sram_re, bus.o_fma_valid}, 0);
        repeat (3) @(negedge clk);
        chk("rstw_stay_idle", o_state, ST_IDLE);
        fma_auto = 1'b1;
        run_vector(1'b1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, "rstw_acc_clear");

        // ---- button mode ----
        do_reset();
        press_byte(8'h00);
        wr0 = wr_a_cnt;
`ifdef FP_MAC_SEQ_BTN_EDGE_EN
        keypad = 8'h11;
        btn = 1'b1;
        repeat (20) @(negedge clk);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        press_byte(8'h22);
        press_byte(8'h33);
`else
        keypad = 8'h11;
        btn = 1'b1;
        @(negedge clk);
        keypad = 8'h22;
        @(negedge clk);
        keypad = 8'h33;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
`endif
        chk("btn_no_wr", wr_a_cnt - wr0, 0);
        press_byte(8'h44);
        repeat (2) @(negedge clk);
        chk("btn_wr", wr_a_cnt - wr0, 1);
        chk("btn_word", mem_a[0], 32'h1122_3344);

        // ---- randomized runs against folded-sum reference ----
        do_reset();
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            fma_lat = $urandom_range(1, 6);
            model_acc = '0;
            for (int i = 0; i < DEP; i++) begin
                ra[i] = $urandom;
                rb[i] = $urandom;
                model_acc = ra[i] * rb[i] + model_acc;
            end
            run_vector(1'b1, ra[0], ra[1], rb[0], rb[1], model_acc, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
